// File: rtl/branch_pkg.sv
// Shared branch definitions: jump codes, ALU status flag positions, resolve FSM states.
// Also imported by the 2-bit predictor, so code values must stay in sync with decode.
package branch_pkg;

    localparam int JTYPE_W    = 5;
    localparam int STATUS_W   = 12;
    localparam int UPD_ADDR_W = 8;

    localparam logic [JTYPE_W-1:0] JC1 = 5'b10000;
    localparam logic [JTYPE_W-1:0] JN1 = 5'b01000;
    localparam logic [JTYPE_W-1:0] JV1 = 5'b00100;
    localparam logic [JTYPE_W-1:0] JZ1 = 5'b00010;
    localparam logic [JTYPE_W-1:0] JC0 = 5'b01110;
    localparam logic [JTYPE_W-1:0] JN0 = 5'b10110;
    localparam logic [JTYPE_W-1:0] JV0 = 5'b11010;
    localparam logic [JTYPE_W-1:0] JZ0 = 5'b11100;

    localparam int FLAG_C = 11;
    localparam int FLAG_N = 10;
    localparam int FLAG_V = 9;
    localparam int FLAG_Z = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        RESOLVE    = 2'd2,
        FLUSH      = 2'd3
    } brState_t;

    typedef struct packed {
        logic [JTYPE_W-1:0] jumpType;
        logic               predTaken;
    } jumpMeta_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump-condition evaluator: (jump code, status bits) -> taken, zero latency.
// No handshake; unrecognised codes are treated as unconditional jumps.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [JTYPE_W-1:0]  jumpType,
    input  logic [STATUS_W-1:0] statusBits,
    output logic                taken
);

    logic flagC, flagN, flagV, flagZ;
    logic unusedStatus;

    assign flagC = statusBits[FLAG_C];
    assign flagN = statusBits[FLAG_N];
    assign flagV = statusBits[FLAG_V];
    assign flagZ = statusBits[FLAG_Z];
    assign unusedStatus = ^statusBits[7:0];

    always_comb begin
        taken = 1'b1;
        case (jumpType)
            JC1:     taken = flagC;
            JN1:     taken = flagN;
            JV1:     taken = flagV;
            JZ1:     taken = flagZ;
            JC0:     taken = ~flagC;
            JN0:     taken = ~flagN;
            JV0:     taken = ~flagV;
            JZ0:     taken = ~flagZ;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves one conditional jump at a time; RESOLVE outputs appear 2 cycles after accept at earliest.
// br_ready is low from accept until the stage returns to IDLE (after the flush on a mispredict).
module branch_resolve
    import branch_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [PC_W-1:0]       br_pc,
    input  logic [PC_W-1:0]       br_target,
    input  logic [JTYPE_W-1:0]    br_jump_type,
    input  logic                  br_pred_taken,
    input  logic                  flags_valid,
    input  logic [STATUS_W-1:0]   status_bits,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc,
    output logic                  flush,
    output logic                  upd_valid,
    output logic [UPD_ADDR_W-1:0] upd_addr,
    output logic                  upd_taken,
    output logic [CNT_W-1:0]      stat_branches,
    output logic [CNT_W-1:0]      stat_mispred
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    brState_t        state, stateNext;
    logic [PC_W-1:0] pcQ, targetQ;
    jumpMeta_t       metaQ;
    logic            mispredQ;
    logic [3:0]      flushCnt;
    logic            actualNow, mispredNow, goResolve, accept;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    branch_cond_eval uCondEval (
        .jumpType   (metaQ.jumpType),
        .statusBits (status_bits),
        .taken      (actualNow)
    );

    assign br_ready   = (state == IDLE);
    assign accept     = br_ready && br_valid;
    assign goResolve  = (state == WAIT_FLAGS) && flags_valid;
    assign mispredNow = actualNow ^ metaQ.predTaken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (br_valid) stateNext = WAIT_FLAGS;
            WAIT_FLAGS: if (flags_valid) stateNext = RESOLVE;
            RESOLVE:    stateNext = (mispredQ && (FLUSH_CYCLES > 1)) ? FLUSH : IDLE;
            FLUSH:      if (flushCnt == 4'd1) stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    // Outputs are registered one edge early so they line up with the RESOLVE/FLUSH cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcQ            <= '0;
            targetQ        <= '0;
            metaQ          <= '0;
            mispredQ       <= 1'b0;
            flushCnt       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            upd_valid      <= 1'b0;
            upd_addr       <= '0;
            upd_taken      <= 1'b0;
            stat_branches  <= '0;
            stat_mispred   <= '0;
        end else begin
            if (accept) begin
                pcQ            <= br_pc;
                targetQ        <= br_target;
                metaQ.jumpType <= br_jump_type;
                metaQ.predTaken <= br_pred_taken;
            end
            if (goResolve) mispredQ <= mispredNow;

            if (state == RESOLVE)    flushCnt <= FLUSH_LOAD;
            else if (state == FLUSH) flushCnt <= flushCnt - 4'd1;

            upd_valid      <= goResolve;
            redirect_valid <= goResolve && mispredNow;
            flush          <= (goResolve && mispredNow) || (stateNext == FLUSH);

            if (goResolve) begin
                upd_addr      <= pcQ[UPD_ADDR_W-1:0];
                upd_taken     <= actualNow;
                stat_branches <= satInc(stat_branches);
                if (mispredNow) begin
                    redirect_pc  <= actualNow ? targetQ : pcQ + PC_W'(1);
                    stat_mispred <= satInc(stat_mispred);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a default instance plus a CNT_W=2 instance for saturation.
module tb_branch_resolve;

    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_valid;
    logic        br_ready;
    logic [15:0] br_pc, br_target;
    logic [4:0]  br_jump_type;
    logic        br_pred_taken;
    logic        flags_valid;
    logic [11:0] status_bits;
    logic        redirect_valid, flush, upd_valid, upd_taken;
    logic [15:0] redirect_pc;
    logic [7:0]  upd_addr;
    logic [15:0] stat_branches, stat_mispred;

    logic        unusedSatReady, unusedSatRedirectValid, unusedSatFlush, unusedSatUpdValid, unusedSatUpdTaken;
    logic [15:0] unusedSatRedirectPc;
    logic [7:0]  unusedSatUpdAddr;
    logic [1:0]  satBranches, satMispred;

    typedef struct {
        logic        taken;
        logic        mispred;
        logic [15:0] rpc;
        logic [7:0]  addr;
    } exp_t;

    exp_t expQ[$];
    int   nVec = 0;
    int   nMis = 0;
    int   expBr = 0, expMis = 0, expSatBr = 0, expSatMis = 0;

    always #5 clk = ~clk;

    branch_resolve #(.PC_W(16), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .br_valid(br_valid), .br_ready(br_ready),
        .br_pc(br_pc), .br_target(br_target), .br_jump_type(br_jump_type),
        .br_pred_taken(br_pred_taken), .flags_valid(flags_valid), .status_bits(status_bits),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_resolve #(.PC_W(16), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(2)) dutSat (
        .clk(clk), .resetn(resetn), .br_valid(br_valid), .br_ready(unusedSatReady),
        .br_pc(br_pc), .br_target(br_target), .br_jump_type(br_jump_type),
        .br_pred_taken(br_pred_taken), .flags_valid(flags_valid), .status_bits(status_bits),
        .redirect_valid(unusedSatRedirectValid), .redirect_pc(unusedSatRedirectPc), .flush(unusedSatFlush),
        .upd_valid(unusedSatUpdValid), .upd_addr(unusedSatUpdAddr), .upd_taken(unusedSatUpdTaken),
        .stat_branches(satBranches), .stat_mispred(satMispred)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nVec++;
        assert (obs === expv) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic modelTaken(input logic [4:0] jt, input logic [11:0] st);
        case (jt)
            5'b10000: return st[11];
            5'b01000: return st[10];
            5'b00100: return st[9];
            5'b00010: return st[8];
            5'b01110: return !st[11];
            5'b10110: return !st[10];
            5'b11010: return !st[9];
            5'b11100: return !st[8];
            default:  return 1'b1;
        endcase
    endfunction

    // Called and returns at a falling edge with the DUT idle.
    task automatic doBranch(input logic [15:0] pc, input logic [15:0] tgt, input logic [4:0] jt,
                            input logic pred, input logic [11:0] st, input int dly);
        exp_t e, got;
        int   guard, fl;
        e.taken   = modelTaken(jt, st);
        e.mispred = e.taken ^ pred;
        e.rpc     = e.taken ? tgt : 16'(pc + 16'd1);
        e.addr    = pc[7:0];
        guard = 0;
        while (br_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("readyTimeout", 32'(guard < 20), 32'd1);
        br_valid = 1'b1; br_pc = pc; br_target = tgt; br_jump_type = jt; br_pred_taken = pred;
        expQ.push_back(e);
        @(negedge clk);
        br_valid = 1'b0; br_pc = ~pc; br_target = ~tgt; br_jump_type = ~jt; br_pred_taken = ~pred;
        for (int i = 0; i < dly; i++) begin
            check("waitNoUpd", 32'(upd_valid), 32'd0);
            check("waitReady", 32'(br_ready), 32'd0);
            @(negedge clk);
        end
        flags_valid = 1'b1; status_bits = st;
        @(negedge clk);
        flags_valid = 1'b0; status_bits = ~st;
        got = expQ.pop_front();
        check("resolveStrobe", 32'(upd_valid), 32'd1);
        check("updTaken", 32'(upd_taken), 32'(got.taken));
        check("updAddr", 32'(upd_addr), 32'(got.addr));
        check("redirectValid", 32'(redirect_valid), 32'(got.mispred));
        check("resolveReady", 32'(br_ready), 32'd0);
        if (got.mispred) check("redirectPc", 32'(redirect_pc), 32'(got.rpc));
        expBr     = (expBr == 65535) ? expBr : expBr + 1;
        expSatBr  = (expSatBr == 3) ? expSatBr : expSatBr + 1;
        if (got.mispred) begin
            expMis    = (expMis == 65535) ? expMis : expMis + 1;
            expSatMis = (expSatMis == 3) ? expSatMis : expSatMis + 1;
        end
        fl = 0;
        while (flush === 1'b1 && fl < 20) begin
            fl++;
            @(negedge clk);
        end
        if (fl == 0) @(negedge clk);
        check("flushCycles", 32'(fl), got.mispred ? 32'(FLUSH_CYCLES) : 32'd0);
        check("readyAfter", 32'(br_ready), 32'd1);
        check("updPulse", 32'(upd_valid), 32'd0);
        check("redirectPulse", 32'(redirect_valid), 32'd0);
        check("statBranches", 32'(stat_branches), 32'(expBr));
        check("statMispred", 32'(stat_mispred), 32'(expMis));
        check("satBranches", 32'(satBranches), 32'(expSatBr));
        check("satMispred", 32'(satMispred), 32'(expSatMis));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; br_valid = 1'b0; br_pc = '0; br_target = '0; br_jump_type = '0;
        br_pred_taken = 1'b0; flags_valid = 1'b0; status_bits = '0;
        @(negedge clk);
        check("rstRedirectValid", 32'(redirect_valid), 32'd0);
        check("rstRedirectPc", 32'(redirect_pc), 32'd0);
        check("rstFlush", 32'(flush), 32'd0);
        check("rstUpdValid", 32'(upd_valid), 32'd0);
        check("rstUpdAddr", 32'(upd_addr), 32'd0);
        check("rstUpdTaken", 32'(upd_taken), 32'd0);
        check("rstStatBranches", 32'(stat_branches), 32'd0);
        check("rstStatMispred", 32'(stat_mispred), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("readyAfterRst", 32'(br_ready), 32'd1);

        // flags_valid while idle must not resolve anything
        flags_valid = 1'b1; status_bits = 12'hFFF;
        @(negedge clk);
        flags_valid = 1'b0;
        check("idleFlagsIgnored", 32'(upd_valid), 32'd0);
        check("idleFlagsReady", 32'(br_ready), 32'd1);

        doBranch(16'h0010, 16'h0020, 5'b11100, 1'b1, 12'h000, 0);  // JZ0, Z=0: taken, correct
        doBranch(16'h0040, 16'h0100, 5'b10000, 1'b1, 12'h000, 0);  // JC1, C=0: redirect 0x0041
        doBranch(16'h0355, 16'h1234, 5'b01000, 1'b0, 12'h400, 0);  // JN1, N=1: redirect 0x1234
        doBranch(16'hFFFF, 16'h0800, 5'b11010, 1'b1, 12'h200, 5);  // JV0, V=1: pc+1 wraps to 0

        // reset dropped in the middle of a flush
        br_valid = 1'b1; br_pc = 16'h0040; br_target = 16'h0200; br_jump_type = 5'b10000; br_pred_taken = 1'b1;
        @(negedge clk);
        br_valid = 1'b0;
        flags_valid = 1'b1; status_bits = 12'h000;
        @(negedge clk);
        flags_valid = 1'b0;
        check("preRstResolveFlush", 32'(flush), 32'd1);
        check("preRstRedirectPc", 32'(redirect_pc), 32'h0041);
        @(negedge clk);
        check("preRstFlushState", 32'(flush), 32'd1);
        resetn = 1'b0;
        #1;
        check("midRstFlush", 32'(flush), 32'd0);
        check("midRstRedirectValid", 32'(redirect_valid), 32'd0);
        check("midRstRedirectPc", 32'(redirect_pc), 32'd0);
        check("midRstUpdAddr", 32'(upd_addr), 32'd0);
        check("midRstStatBranches", 32'(stat_branches), 32'd0);
        check("midRstStatMispred", 32'(stat_mispred), 32'd0);
        check("midRstSatBranches", 32'(satBranches), 32'd0);
        check("midRstReady", 32'(br_ready), 32'd1);
        expBr = 0; expMis = 0; expSatBr = 0; expSatMis = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("noReplayRedirect", 32'(redirect_valid), 32'd0);
        check("noReplayFlush", 32'(flush), 32'd0);

        doBranch(16'h0001, 16'h0002, 5'b00010, 1'b1, 12'h100, 0);  // JZ1, Z=1: correct
        doBranch(16'h0002, 16'h0003, 5'b00001, 1'b1, 12'h000, 1);  // unknown code: taken, correct
        doBranch(16'h0003, 16'h0004, 5'b10110, 1'b0, 12'h400, 0);  // JN0, N=1: not taken, correct
        doBranch(16'h0004, 16'h0044, 5'b01110, 1'b0, 12'h000, 0);  // JC0, C=0: mispredict
        doBranch(16'h0005, 16'h0055, 5'b00100, 1'b1, 12'h000, 2);  // JV1, V=0: mispredict
        doBranch(16'h0006, 16'h0066, 5'b11100, 1'b1, 12'h100, 0);  // JZ0, Z=1: mispredict
        doBranch(16'h0007, 16'hBEEF, 5'b00000, 1'b0, 12'hFFF, 0);  // unknown, pred 0: redirect target

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage directly downstream of the 2-bit branch predictor. Accepts one conditional jump at a time with its predicted direction and evaluates the real condition against the ALU status flags. On a mispredict it issues a PC redirect and a multi-cycle pipeline flush. It also returns a training update (address, actual outcome) to the predictor and keeps saturating branch/mispredict statistics.

## Interface
- `PC_W`, 16, program-counter / target width
- `FLUSH_CYCLES`, 2, cycles `flush` is held on a mispredict (legal 1..15)
- `CNT_W`, 16, statistics counter width
- `clk` in 1: single clock, all state on rising edge
- `resetn` in 1: reset, asynchronous and active-low
- `br_valid` in 1: conditional jump presented
- `br_ready` out 1: stage can accept; `(state == IDLE)`
- `br_pc` in PC_W: address of the jump instruction
- `br_target` in PC_W: effective jump target
- `br_jump_type` in 5: jump code
- `br_pred_taken` in 1: predictor's `jumpTaken`
- `flags_valid` in 1: `status_bits` are final for the captured jump
- `status_bits` in 12: C=bit 11, N=bit 10, V=bit 9, Z=bit 8; others ignored
- `redirect_valid` out 1: one-cycle pulse, fetch must load `redirect_pc`
- `redirect_pc` out PC_W: corrected PC
- `flush` out 1: kill younger instructions
- `upd_valid` out 1: one-cycle training strobe to predictor
- `upd_addr` out 8: `br_pc[7:0]` of resolved jump
- `upd_taken` out 1: actual outcome
- `stat_branches` out CNT_W: resolved-jump count
- `stat_mispred` out CNT_W: mispredict count

## Operation
- Jump codes: JC1 `10000` (C==1), JN1 `01000` (N==1), JV1 `00100` (V==1), JZ1 `00010` (Z==1), JC0 `01110` (C==0), JN0 `10110` (N==0), JV0 `11010` (V==0), JZ0 `11100` (Z==0). Any other code: actual = taken (unconditional).
- States: IDLE, WAIT_FLAGS, RESOLVE, FLUSH.
- IDLE: `br_valid` -> capture pc, target, type, prediction; go WAIT_FLAGS. `flags_valid` ignored.
- WAIT_FLAGS: hold until `flags_valid`; then register actual outcome and `mispred = actual ^ pred`; go RESOLVE.
- RESOLVE (exactly one cycle): `upd_valid`=1; `stat_branches`+1. If mispred: `redirect_valid`=1, `redirect_pc` = actual ? target : pc+1 (mod 2^PC_W, 0xFFFF wraps to 0x0000), `flush`=1, `stat_mispred`+1, go FLUSH if FLUSH_CYCLES>1 else IDLE. Else go IDLE, no redirect/flush.
- FLUSH: `flush`=1; counter loaded with FLUSH_CYCLES-1 on RESOLVE exit, decrements each cycle; leave to IDLE when it reaches 1. Total `flush` high = FLUSH_CYCLES cycles, starting in RESOLVE.
- Counters saturate at all-ones; never wrap.
- `br_valid` outside IDLE is not accepted (`br_ready`=0); upstream holds it.

## Timing
- All outputs except `br_ready` registered. Reset values: every output 0, state IDLE, counters 0, `br_ready`=1 after reset release.
- Accept at cycle T; earliest `flags_valid` sampled T+1; RESOLVE outputs visible T+2. Minimum issue interval 3 cycles (correct), 2+FLUSH_CYCLES (mispredict).
- `redirect_valid`, `upd_valid` single-cycle pulses coincident with first `flush` cycle.
- `resetn` low at any point (incl. mid-FLUSH): immediate return to IDLE, all outputs 0, counters cleared; no pending redirect replayed.
- Statistic at saturation plus a new event: stays all-ones, other counter still increments.

## Structure
- Shared package `branch_pkg`: jump-type codes, flag bit indices (C/N/V/Z), state enum; also used by the predictor.
- Sub-module `branch_cond_eval`: combinational (jump_type, status_bits) -> taken; reusable by execute stage.

## Test plan
- JZ0, pred=1, Z=0 at T+1 -> T+2: `upd_valid`=1, `upd_taken`=1, no redirect/flush, `stat_branches`=1, `stat_mispred`=0.
- JC1, pred=1, C=0, pc=0x0040 -> `redirect_pc`=0x0041, `flush` high 2 cycles, `br_ready` low until T+4, `stat_mispred`=1.
- JN1, pred=0, N=1, target=0x1234 -> `redirect_pc`=0x1234, `upd_addr`=pc[7:0], `upd_taken`=1.
- pc=0xFFFF, JV0 mispredicted not-taken-actual -> `redirect_pc`=0x0000; `flags_valid` delayed 5 cycles -> RESOLVE exactly 1 cycle after it.
- `resetn` dropped during FLUSH -> all outputs 0 same cycle (async), counters 0, next `br_valid` after release accepted.
- CNT_W=2, four mispredicts -> both counters saturate at 3; unknown code `00000` with pred=0 -> counted mispredict, redirect to target.
